// File: rtl/pixel_fb_pkg.sv
// pixel_fb_pkg: shared state type, index helper and width helpers for pixel_framebuffer
package pixel_fb_pkg;
  typedef enum logic {IDLE, CLEAR} fb_state_t;
  localparam int FB_DEF_WIDTH = 320;
  localparam int FB_DEF_HEIGHT = 240;
  function automatic int fb_idx_w(input int width, input int height);
    return (width * height > 1) ? $clog2(width * height) : 1;
  endfunction
  function automatic int fb_coord_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int unsigned fb_index(input int unsigned x, input int unsigned y, input int unsigned width);
    return y * width + x;
  endfunction
endpackage

// File: rtl/pixel_fb_scan_fifo.sv
// pixel_fb_scan_fifo: 2-entry {eof, pixel} FIFO with flush, occupancy count and valid/ready output
module pixel_fb_scan_fifo #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp, pop;
  assign valid = count != 2'd0;
  assign pop = valid & ready;
  assign dout = valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (push & ~flush) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/pixel_framebuffer.sv
// pixel_framebuffer: single-port pixel RAM shared by a clear engine, raster scan-out and a CPU port
import pixel_fb_pkg::*;

module pixel_framebuffer #(
  parameter int    N = 32,
  parameter int    BPP = 2,
  parameter int    WIDTH = FB_DEF_WIDTH,
  parameter int    HEIGHT = FB_DEF_HEIGHT,
  parameter string INIT_FILE = ""
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic [N-1:0]   cpu_addr,
  input  logic [N-1:0]   cpu_wdata,
  output logic           cpu_ack,
  output logic           cpu_err,
  output logic [N-1:0]   cpu_rdata,
  input  logic           scan_start,
  output logic           scan_valid,
  input  logic           scan_ready,
  output logic [BPP-1:0] scan_pixel,
  output logic           scan_eof,
  input  logic           clr_start,
  input  logic [BPP-1:0] clr_color,
  output logic           busy
);
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int IW = fb_idx_w(WIDTH, HEIGHT);
  localparam int XW = fb_coord_w(WIDTH);
  localparam int YW = fb_coord_w(HEIGHT);
  localparam int HW = N / 2;
  fb_state_t state, state_nxt;
  logic [BPP-1:0] mem [DEPTH];
  logic [IW-1:0] clr_idx, scan_idx, cpu_idx, ram_a;
  logic [BPP-1:0] clr_col, ram_wd, ram_q;
  logic [HW-1:0] cx;
  logic [N-HW-1:0] cy;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic [1:0] fifo_cnt;
  logic [2:0] occ;
  logic [BPP:0] fifo_dout;
  logic ram_we, clr_now, clr_go, clr_last, in_range, cpu_oor, cpu_gnt, rd_ack;
  logic scan_act, scan_pend, start_go, fetch, sf_v, sf_eof, scan_last, x_last, pop;
  logic unused_wdata;
  assign unused_wdata = ^cpu_wdata[N-1:BPP];
  assign clr_now = state == CLEAR;
  assign clr_go = (state == IDLE) & clr_start;
  assign clr_last = clr_idx == IW'(DEPTH - 1);
  assign busy = clr_now;
  assign cx = cpu_addr[HW-1:0];
  assign cy = cpu_addr[N-1:HW];
  assign in_range = (int'(cx) < WIDTH) && (int'(cy) < HEIGHT);
  assign cpu_oor = cpu_req & ~in_range;
  assign cpu_idx = IW'(fb_index(32'(cx), 32'(cy), WIDTH));
  assign scan_idx = IW'(fb_index(32'(sx), 32'(sy), WIDTH));
  assign x_last = sx == XW'(WIDTH - 1);
  assign scan_last = x_last && (sy == YW'(HEIGHT - 1));
  // A scan start held off by a clear is replayed on the first IDLE cycle
  assign start_go = (scan_start | scan_pend) & ~clr_now;
  assign pop = scan_valid & scan_ready;
  // Counting the pop in the same cycle is what sustains one pixel per cycle
  assign occ = 3'(fifo_cnt) + 3'(sf_v) - 3'(pop);
  assign fetch = scan_act & ~clr_now & ~start_go & (occ < 3'd2);
  assign cpu_gnt = cpu_req & in_range & ~clr_now & ~clr_go & ~fetch;
  assign ram_we = clr_now | (cpu_gnt & cpu_we);
  assign ram_a = clr_now ? clr_idx : fetch ? scan_idx : cpu_idx;
  assign ram_wd = clr_now ? clr_col : cpu_wdata[BPP-1:0];
  assign cpu_rdata = rd_ack ? N'(ram_q) : '0;
  assign {scan_eof, scan_pixel} = fifo_dout;
  always_comb
    state_nxt = clr_go ? CLEAR : (clr_now && clr_last) ? IDLE : state;
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_wd;
    ram_q <= mem[ram_a];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      clr_idx <= '0;
      clr_col <= '0;
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      rd_ack <= 1'b0;
      scan_act <= 1'b0;
      scan_pend <= 1'b0;
      sx <= '0;
      sy <= '0;
      sf_v <= 1'b0;
      sf_eof <= 1'b0;
    end else begin
      state <= state_nxt;
      clr_idx <= clr_go ? '0 : clr_idx + IW'(clr_now);
      if (clr_go) clr_col <= clr_color;
      cpu_ack <= cpu_gnt | cpu_oor;
      cpu_err <= cpu_oor;
      rd_ack <= cpu_gnt & ~cpu_we;
      scan_pend <= clr_now & (scan_start | scan_pend);
      sf_v <= fetch;
      sf_eof <= fetch & scan_last;
      if (start_go) begin
        scan_act <= 1'b1;
        sx <= '0;
        sy <= '0;
      end else if (fetch) begin
        sx <= x_last ? '0 : sx + 1'b1;
        if (x_last) sy <= sy + 1'b1;
        if (scan_last) scan_act <= 1'b0;
      end
    end
  pixel_fb_scan_fifo #(.W(BPP + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (start_go),
    .push  (sf_v),
    .din   ({sf_eof, ram_q}),
    .ready (scan_ready),
    .valid (scan_valid),
    .dout  (fifo_dout),
    .count (fifo_cnt)
  );
endmodule

// File: tb/tb_pixel_framebuffer.sv
// tb_pixel_framebuffer: directed checks of CPU access, clear engine and scan-out on a 16x8 frame
module tb_pixel_framebuffer;
  localparam int W = 16, H = 8, D = W * H;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack, cpu_err;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic scan_start = 1'b0, scan_valid, scan_ready = 1'b0, scan_eof;
  logic [1:0] scan_pixel, clr_color = '0;
  logic clr_start = 1'b0, busy;
  logic [1:0] model [D];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pixel_framebuffer #(.N(32), .BPP(2), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .scan_start(scan_start), .scan_valid(scan_valid), .scan_ready(scan_ready),
    .scan_pixel(scan_pixel), .scan_eof(scan_eof), .clr_start(clr_start),
    .clr_color(clr_color), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cpu_xfer(input logic we, input int x, input int y, input logic [1:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = {16'(y), 16'(x)};
    cpu_wdata = {30'h3ffffff0, wd};
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!cpu_ack && lat < 500);
    rd = cpu_rdata;
    er = cpu_err;
    cpu_req = 1'b0;
  endtask
  initial begin
    logic [31:0] rd;
    logic er, stalled, restarted, restart_chk;
    logic [1:0] pp;
    logic pe;
    int lat, n, ack_at, beats, first, bad, eofbad, gaps, k, hold_bad;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", cpu_ack, 0);
    check("rst_err", cpu_err, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_valid", scan_valid, 0);
    check("rst_pixel", scan_pixel, 0);
    check("rst_eof", scan_eof, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cpu_xfer(1'b1, 5, 3, 2'b10, rd, er, lat);
    check("wr_lat", lat, 1);
    check("wr_err", er, 0);
    cpu_xfer(1'b0, 5, 3, 2'b00, rd, er, lat);
    check("rd_lat", lat, 1);
    check("rd_data", rd, 32'h2);
    check("rd_err", er, 0);
    cpu_xfer(1'b1, 0, 1, 2'b01, rd, er, lat);
    cpu_xfer(1'b0, 0, H, 2'b00, rd, er, lat);
    check("oor_rd_lat", lat, 1);
    check("oor_rd_err", er, 1);
    check("oor_rd_data", rd, 0);
    cpu_xfer(1'b1, W, 0, 2'b11, rd, er, lat);
    check("oor_wr_err", er, 1);
    cpu_xfer(1'b0, 0, 1, 2'b00, rd, er, lat);
    check("oor_ram_kept", rd, 32'h1);
    check("oor_ram_kept_err", er, 0);
    clr_color = 2'b11;
    clr_start = 1'b1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = {16'd3, 16'd5};
    n = 0;
    ack_at = 0;
    for (int i = 1; i <= 400 && ack_at == 0; i++) begin
      @(posedge clk); #1;
      clr_start = 1'b0;
      if (busy) n++;
      if (cpu_ack) begin
        ack_at = i;
        rd = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    check("clr_busy_cycles", n, D);
    check("clr_cpu_ack_cycle", ack_at, D + 2);
    check("clr_cpu_rdata", rd, 32'h3);
    for (int i = 0; i < 10; i++) begin
      cpu_xfer(1'b0, int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)), 2'b00, rd, er, lat);
      check("clr_rand_rd", rd, 32'h3);
    end
    for (int i = 0; i < D; i++) begin
      model[i] = 2'((i ^ (i >> 3)) & 3);
      cpu_xfer(1'b1, i % W, i / W, model[i], rd, er, lat);
    end
    scan_ready = 1'b1;
    scan_start = 1'b1;
    first = 0; beats = 0; bad = 0; eofbad = 0; gaps = 0;
    for (int i = 1; i <= 400 && beats < D; i++) begin
      @(posedge clk); #1;
      scan_start = 1'b0;
      if (scan_valid) begin
        if (beats == 0) first = i;
        if (scan_pixel !== model[beats]) bad++;
        if (scan_eof !== (beats == D - 1)) eofbad++;
        beats++;
      end else if (beats > 0) gaps++;
    end
    check("scan_beats", beats, D);
    check("scan_first_cycle", first, 3);
    check("scan_pixel_order", bad, 0);
    check("scan_eof_pos", eofbad, 0);
    check("scan_gaps", gaps, 0);
    @(posedge clk); #1;
    check("scan_done_idle", scan_valid, 0);
    scan_ready = 1'b0;
    scan_start = 1'b1;
    k = 0; bad = 0; eofbad = 0; hold_bad = 0;
    stalled = 1'b0; restarted = 1'b0; restart_chk = 1'b0; pp = '0; pe = 1'b0;
    for (int i = 0; i < 3000 && k < D; i++) begin
      @(posedge clk); #1;
      scan_start = 1'b0;
      if (restart_chk) begin
        check("restart_valid_low", scan_valid, 0);
        restart_chk = 1'b0;
      end
      if (stalled && (!scan_valid || scan_pixel !== pp || scan_eof !== pe)) hold_bad++;
      if (!restarted && k == 50) begin
        scan_start = 1'b1;
        scan_ready = 1'b0;
        restarted = 1'b1;
        restart_chk = 1'b1;
        stalled = 1'b0;
        k = 0;
        continue;
      end
      scan_ready = 1'($urandom_range(0, 1));
      stalled = scan_valid & ~scan_ready;
      pp = scan_pixel;
      pe = scan_eof;
      if (scan_valid && scan_ready) begin
        if (scan_pixel !== model[k]) bad++;
        if (scan_eof !== (k == D - 1)) eofbad++;
        k++;
      end
    end
    scan_ready = 1'b0;
    check("rand_beats", k, D);
    check("rand_pixel_order", bad, 0);
    check("rand_eof_pos", eofbad, 0);
    check("rand_hold", hold_bad, 0);
    clr_color = 2'b01;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("busy_mid_clear", busy, 1);
    rst_n = 1'b0;
    #1;
    check("busy_in_reset", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("busy_after_reset", busy, 0);
    cpu_xfer(1'b0, 0, 0, 2'b00, rd, er, lat);
    check("post_rst_lat", lat, 1);
    check("post_rst_cleared", rd, 32'h1);
    cpu_xfer(1'b0, W - 1, H - 1, 2'b00, rd, er, lat);
    check("post_rst_uncleared", rd, 32'(model[D-1]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
